// File: rtl/kf_host_ctrl.sv
// -----------------------------------------------------------------------------
// kf_host_ctrl
//
// Host-side driver for the Kalman filter core. It takes one command at a time
// from a valid/ready stream and runs it against the core:
//   op 00 : ROM write    (rom_we pulse, rom_waddr = cmd_addr, rom_wdata = cmd_data[15:0])
//   op 01 : data write   (WRITE pulse, DIR = cmd_addr[ADDRW-1:0], DATA_IN = cmd_data)
//   op 10 : run          (START pulse, wait for READY low then high, report DATA_OUT
//                         and the cycle count)
//   op 11 : read         (report DATA_OUT sampled in the accept cycle)
// Every command produces exactly one response on the rsp_* stream.
//
// Optional feature (compile-time macro KF_HOST_TIMEOUT_EN):
//   defined   - a run that keeps READY low until the cycle counter reaches
//               TMO_CYC is abandoned with rsp_err=1, rsp_data=0 and
//               rsp_cycles=TMO_CYC. The core itself is left alone.
//   undefined - a run waits for READY indefinitely and rsp_err is tied to 0.
//
// Parameters:
//   W       data width of the core datapath
//   ADDRW   data-bank address width (DIR)
//   CNTW    run-cycle counter width
//   ARM_CYC cycles to wait for READY to fall after START
//   TMO_CYC run watchdog limit (used only with KF_HOST_TIMEOUT_EN)
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_op/cmd_addr/cmd_data  command fields
//   rsp_valid/rsp_ready       response handshake
//   rsp_data/rsp_cycles/rsp_err  response fields
//   rom_we/rom_waddr/rom_wdata   core ROM write port
//   DATA_IN/DIR/WRITE         core data-bank write port
//   START/READY/DATA_OUT      core run control and result
//
// Run cycle count: the count equals the number of cycles since the accept
// edge, so the START cycle counts as 1 and the cycle in which READY returns
// high is the value reported. A zero-length program (READY never falls)
// reports the count of the cycle in which it is given up, ARM_CYC + 1.
// -----------------------------------------------------------------------------
module kf_host_ctrl #(
    parameter int W       = 24,
    parameter int ADDRW   = 5,
    parameter int CNTW    = 16,
    parameter int ARM_CYC = 4,
    parameter int TMO_CYC = 4095
) (
    input  logic             clk,
    input  logic             rst,
    // command stream
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_addr,
    input  logic [W-1:0]     cmd_data,
    // response stream
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic [CNTW-1:0]  rsp_cycles,
    output logic             rsp_err,
    // core ROM write port
    output logic             rom_we,
    output logic [7:0]       rom_waddr,
    output logic [15:0]      rom_wdata,
    // core data bank and run control
    output logic [W-1:0]     DATA_IN,
    output logic [ADDRW-1:0] DIR,
    output logic             WRITE,
    output logic             START,
    input  logic             READY,
    input  logic [W-1:0]     DATA_OUT
);

    // Parameter sanity: the ROM word is taken from cmd_data[15:0], and both
    // cycle limits must be representable in the counter.
    if (W < 16) begin : g_bad_w
        $error("kf_host_ctrl: W must be at least 16");
    end
    if (ADDRW < 1 || ADDRW > 8) begin : g_bad_addrw
        $error("kf_host_ctrl: ADDRW must be 1..8");
    end
    if (ARM_CYC < 1 || ARM_CYC + 1 >= 2**CNTW) begin : g_bad_arm
        $error("kf_host_ctrl: ARM_CYC out of range for CNTW");
    end
    if (TMO_CYC < 1 || TMO_CYC >= 2**CNTW) begin : g_bad_tmo
        $error("kf_host_ctrl: TMO_CYC out of range for CNTW");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROMW,
        S_DATW,
        S_STRT,
        S_ARM,
        S_RUN,
        S_RESP
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] ARM_LAST = CNTW'(ARM_CYC + 1);
`ifdef KF_HOST_TIMEOUT_EN
    localparam logic [CNTW-1:0] TMO_LIM  = CNTW'(TMO_CYC);
`endif

    state_t            state_q;
    logic              en_q;          // IDLE and allowed to accept
    logic [CNTW-1:0]   cnt_q;
    logic [CNTW-1:0]   cnt_d;

    logic              rsp_valid_q;
    logic [W-1:0]      rsp_data_q;
    logic [CNTW-1:0]   rsp_cycles_q;
`ifdef KF_HOST_TIMEOUT_EN
    logic              rsp_err_q;
`endif

    logic              rom_we_q;
    logic [7:0]        rom_waddr_q;
    logic [15:0]       rom_wdata_q;
    logic [W-1:0]      data_in_q;
    logic [ADDRW-1:0]  dir_q;
    logic              write_q;
    logic              start_q;

    logic              accept;

    // en_q is a register so cmd_ready is 0 throughout reset even though the
    // core may already be signalling READY; it also keeps accept out of the
    // response handshake cycle.
    assign cmd_ready = en_q & READY;
    assign accept    = cmd_valid & cmd_ready;

    // Saturating increment: a stuck core must not wrap the count back to a
    // small, plausible-looking run length.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            en_q         <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_cycles_q <= '0;
`ifdef KF_HOST_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
`endif
            rom_we_q     <= 1'b0;
            rom_waddr_q  <= '0;
            rom_wdata_q  <= '0;
            data_in_q    <= '0;
            dir_q        <= '0;
            write_q      <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            // Strobes are single-cycle; they are set only on entry to their state.
            rom_we_q <= 1'b0;
            write_q  <= 1'b0;
            start_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    en_q <= ~accept;
                    if (accept) begin
                        case (cmd_op)
                            2'b00: begin
                                rom_waddr_q <= cmd_addr;
                                rom_wdata_q <= cmd_data[15:0];
                                rom_we_q    <= 1'b1;
                                state_q     <= S_ROMW;
                            end
                            2'b01: begin
                                dir_q     <= cmd_addr[ADDRW-1:0];
                                data_in_q <= cmd_data;
                                write_q   <= 1'b1;
                                state_q   <= S_DATW;
                            end
                            2'b10: begin
                                start_q <= 1'b1;
                                cnt_q   <= CNT_ONE;
                                state_q <= S_STRT;
                            end
                            default: begin
                                rsp_data_q  <= DATA_OUT;
                                rsp_valid_q <= 1'b1;
                                state_q     <= S_RESP;
                            end
                        endcase
                    end
                end

                S_ROMW, S_DATW: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end

                S_STRT: begin
                    cnt_q   <= cnt_d;
                    state_q <= S_ARM;
                end

                // READY must fall within ARM_CYC cycles of START; if it never
                // does, the program is taken to have finished immediately.
                S_ARM: begin
                    if (!READY) begin
                        cnt_q   <= cnt_d;
                        state_q <= S_RUN;
                    end else if (cnt_q >= ARM_LAST) begin
                        rsp_data_q   <= DATA_OUT;
                        rsp_cycles_q <= cnt_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_RUN: begin
                    if (READY) begin
                        rsp_data_q   <= DATA_OUT;
                        rsp_cycles_q <= cnt_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
`ifdef KF_HOST_TIMEOUT_EN
                    end else if (cnt_q >= TMO_LIM) begin
                        rsp_err_q    <= 1'b1;
                        rsp_data_q   <= '0;
                        rsp_cycles_q <= TMO_LIM;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                // Fields are cleared on the way out so they read 0 whenever
                // no response is pending.
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        rsp_data_q   <= '0;
                        rsp_cycles_q <= '0;
`ifdef KF_HOST_TIMEOUT_EN
                        rsp_err_q    <= 1'b0;
`endif
                        en_q         <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end

                default: begin
                    en_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_cycles = rsp_cycles_q;
`ifdef KF_HOST_TIMEOUT_EN
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif

    assign rom_we    = rom_we_q;
    assign rom_waddr = rom_waddr_q;
    assign rom_wdata = rom_wdata_q;
    assign DATA_IN   = data_in_q;
    assign DIR       = dir_q;
    assign WRITE     = write_q;
    assign START     = start_q;

endmodule

// File: tb/tb_kf_host_ctrl.sv
module tb_kf_host_ctrl;

    localparam int W       = 24;
    localparam int ADDRW   = 5;
    localparam int CNTW    = 16;
    localparam int ARM_CYC = 4;
    localparam int TMO_CYC = 50;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [7:0]       cmd_addr = 8'h00;
    logic [W-1:0]     cmd_data = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [W-1:0]     rsp_data;
    logic [CNTW-1:0]  rsp_cycles;
    logic             rsp_err;
    logic             rom_we;
    logic [7:0]       rom_waddr;
    logic [15:0]      rom_wdata;
    logic [W-1:0]     DATA_IN;
    logic [ADDRW-1:0] DIR;
    logic             WRITE;
    logic             START;
    logic             READY;
    logic [W-1:0]     DATA_OUT = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    kf_host_ctrl #(
        .W(W), .ADDRW(ADDRW), .CNTW(CNTW), .ARM_CYC(ARM_CYC), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cycles(rsp_cycles), .rsp_err(rsp_err),
        .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
        .DATA_IN(DATA_IN), .DIR(DIR), .WRITE(WRITE), .START(START),
        .READY(READY), .DATA_OUT(DATA_OUT)
    );

    // Core model: on START it drops READY for core_len cycles, then raises it.
    int   core_len      = 10;
    bit   core_drop     = 1'b1;
    bit   core_hold_low = 1'b0;
    int   busy          = 0;
    logic ready_m       = 1'b1;
    assign READY = ready_m;

    always @(posedge clk) begin
        if (rst) begin
            ready_m <= 1'b1;
            busy    <= 0;
        end else if (busy > 0) begin
            busy <= busy - 1;
            if (busy == 1) ready_m <= 1'b1;
        end else if (START && core_drop) begin
            ready_m <= 1'b0;
            busy    <= core_len;
        end else begin
            ready_m <= ~core_hold_low;
        end
    end

    // Strobe counters for pulse-count and exclusivity checks.
    int n_start = 0;
    int n_write = 0;
    int n_romwe = 0;
    bit overlap = 1'b0;
    always @(posedge clk) begin
        if (START === 1'b1)  n_start++;
        if (WRITE === 1'b1)  n_write++;
        if (rom_we === 1'b1) n_romwe++;
        if (int'(START) + int'(WRITE) + int'(rom_we) > 1) overlap = 1'b1;
    end

    // Drive a command and return just after the accept edge.
    task automatic send(input logic [1:0] op, input logic [7:0] addr,
                        input logic [W-1:0] data, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Cycles from the accept edge until rsp_valid is seen; -1 if never.
    task automatic wait_rsp(input int maxc, output int lat);
        lat = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic ack_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, rom_we, WRITE, START} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {cmd_ready, rsp_valid, rsp_err, rom_we, WRITE, START});
        end
        checks++;
        if ({rsp_data, rsp_cycles, rom_waddr, rom_wdata, DATA_IN, DIR} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0",
                     {rsp_data, rsp_cycles, rom_waddr, rom_wdata, DATA_IN, DIR});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_rom_write();
        bit ok;
        int lat;
        int r0;
        r0 = n_romwe;
        send(2'b00, 8'h05, 24'h5AA1B2, ok);
        @(negedge clk);
        checks++;
        if (!ok || rom_we !== 1'b1 || rom_waddr !== 8'h05 || rom_wdata !== 16'hA1B2) begin
            errors++;
            $display("FAIL rom_pulse: ok=%0d we=%b addr=%h data=%h required 1 1 05 a1b2",
                     ok, rom_we, rom_waddr, rom_wdata);
        end
        checks++;
        if ({WRITE, START} !== 2'b00) begin
            errors++;
            $display("FAIL rom_other_strobes: got %b required 00", {WRITE, START});
        end
        wait_rsp(10, lat);
        checks++;
        if (lat + 1 != 2) begin
            errors++;
            $display("FAIL rom_latency: got %0d required 2", lat + 1);
        end
        checks++;
        if (rom_we !== 1'b0 || rsp_data !== '0 || rsp_cycles !== '0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rom_rsp: we=%b data=%h cycles=%0d err=%b required 0 0 0 0",
                     rom_we, rsp_data, rsp_cycles, rsp_err);
        end
        ack_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rom_done: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
        checks++;
        if (n_romwe - r0 != 1) begin
            errors++;
            $display("FAIL rom_pulse_count: got %0d required 1", n_romwe - r0);
        end
    endtask

    task automatic test_data_write();
        bit ok;
        int lat;
        int s0;
        int w0;
        s0 = n_start;
        w0 = n_write;
        send(2'b01, 8'h03, 24'h004000, ok);
        @(negedge clk);
        checks++;
        if (!ok || WRITE !== 1'b1 || DIR !== 5'd3 || DATA_IN !== 24'h004000) begin
            errors++;
            $display("FAIL dat_pulse: ok=%0d write=%b dir=%0d data_in=%h required 1 1 3 004000",
                     ok, WRITE, DIR, DATA_IN);
        end
        wait_rsp(10, lat);
        checks++;
        if (lat + 1 != 2 || rsp_data !== '0) begin
            errors++;
            $display("FAIL dat_rsp: latency=%0d data=%h required 2 0", lat + 1, rsp_data);
        end
        ack_rsp();
        checks++;
        if (n_start != s0 || n_write - w0 != 1) begin
            errors++;
            $display("FAIL dat_counts: start=%0d write=%0d required 0 1", n_start - s0, n_write - w0);
        end
    endtask

    task automatic test_read_backpressure();
        bit ok;
        int lat;
        int stable;
        DATA_OUT = 24'h123456;
        send(2'b11, 8'h00, 24'h000000, ok);
        DATA_OUT = 24'h777777;
        wait_rsp(10, lat);
        checks++;
        if (!ok || lat != 1 || rsp_data !== 24'h123456 || rsp_cycles !== '0) begin
            errors++;
            $display("FAIL read_rsp: latency=%0d data=%h cycles=%0d required 1 123456 0",
                     lat, rsp_data, rsp_cycles);
        end
        stable = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && rsp_data === 24'h123456 && rsp_cycles === '0 && rsp_err === 1'b0)
                stable++;
        end
        checks++;
        if (stable != 5) begin
            errors++;
            $display("FAIL read_hold: stable cycles %0d required 5", stable);
        end
        ack_rsp();
    endtask

    task automatic test_run();
        bit ok;
        int lat;
        int s0;
        int stable;
        core_drop = 1'b1;
        core_len  = 10;
        DATA_OUT  = 24'h00C000;
        s0 = n_start;
        send(2'b10, 8'h00, 24'h000000, ok);
        wait_rsp(40, lat);
        checks++;
        if (!ok || lat != 13) begin
            errors++;
            $display("FAIL run_latency: got %0d required 13", lat);
        end
        checks++;
        if (rsp_data !== 24'h00C000 || rsp_cycles !== 16'd12 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL run_rsp: data=%h cycles=%0d err=%b required 00c000 12 0",
                     rsp_data, rsp_cycles, rsp_err);
        end
        DATA_OUT = 24'hFFFFFF;
        stable = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && rsp_data === 24'h00C000 && rsp_cycles === 16'd12)
                stable++;
        end
        checks++;
        if (stable != 5) begin
            errors++;
            $display("FAIL run_hold: stable cycles %0d required 5", stable);
        end
        ack_rsp();
        checks++;
        if (n_start - s0 != 1) begin
            errors++;
            $display("FAIL run_start_count: got %0d required 1", n_start - s0);
        end
    endtask

    task automatic test_busy_core();
        bit ok;
        int lat;
        int w0;
        int bad;
        core_hold_low = 1'b1;
        repeat (2) @(negedge clk);
        w0 = n_write;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_addr  = 8'h07;
        cmd_data  = 24'h0000AA;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (cmd_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || n_write != w0) begin
            errors++;
            $display("FAIL busy_hold: ready cycles %0d writes %0d required 0 0", bad, n_write - w0);
        end
        core_hold_low = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (!ok || WRITE !== 1'b1 || DIR !== 5'd7 || DATA_IN !== 24'h0000AA) begin
            errors++;
            $display("FAIL busy_release: ok=%0d write=%b dir=%0d data_in=%h required 1 1 7 0000aa",
                     ok, WRITE, DIR, DATA_IN);
        end
        wait_rsp(10, lat);
        ack_rsp();
    endtask

    task automatic test_zero_length();
        bit ok;
        int lat;
        core_drop = 1'b0;
        DATA_OUT  = 24'h0ABCDE;
        send(2'b10, 8'h00, 24'h000000, ok);
        wait_rsp(20, lat);
        checks++;
        if (!ok || lat != ARM_CYC + 2) begin
            errors++;
            $display("FAIL zero_latency: got %0d required %0d", lat, ARM_CYC + 2);
        end
        checks++;
        if (rsp_data !== 24'h0ABCDE || rsp_cycles !== 16'(ARM_CYC + 1) || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_rsp: data=%h cycles=%0d err=%b required 0abcde %0d 0",
                     rsp_data, rsp_cycles, rsp_err, ARM_CYC + 1);
        end
        ack_rsp();
        core_drop = 1'b1;
    endtask

    task automatic test_timeout();
        bit ok;
        int lat;
`ifdef KF_HOST_TIMEOUT_EN
        core_len = 1000;
        DATA_OUT = 24'h555555;
        send(2'b10, 8'h00, 24'h000000, ok);
        wait_rsp(80, lat);
        checks++;
        if (!ok || lat != TMO_CYC + 1) begin
            errors++;
            $display("FAIL tmo_latency: got %0d required %0d", lat, TMO_CYC + 1);
        end
        checks++;
        if (rsp_err !== 1'b1 || rsp_cycles !== 16'(TMO_CYC) || rsp_data !== '0) begin
            errors++;
            $display("FAIL tmo_rsp: err=%b cycles=%0d data=%h required 1 %0d 0",
                     rsp_err, rsp_cycles, rsp_data, TMO_CYC);
        end
        ack_rsp();
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL tmo_core_busy: cmd_ready=%b required 0", cmd_ready);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`else
        core_len = 60;
        DATA_OUT = 24'h00BEEF;
        send(2'b10, 8'h00, 24'h000000, ok);
        wait_rsp(100, lat);
        checks++;
        if (!ok || lat != 63) begin
            errors++;
            $display("FAIL long_run_latency: got %0d required 63", lat);
        end
        checks++;
        if (rsp_err !== 1'b0 || rsp_cycles !== 16'd62 || rsp_data !== 24'h00BEEF) begin
            errors++;
            $display("FAIL long_run_rsp: err=%b cycles=%0d data=%h required 0 62 00beef",
                     rsp_err, rsp_cycles, rsp_data);
        end
        ack_rsp();
`endif
        core_len = 10;
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int lat;
        int bad;
        core_len = 1000;
        send(2'b10, 8'h00, 24'h000000, ok);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({START, WRITE, rom_we, rsp_valid, cmd_ready} !== 5'b0) begin
            errors++;
            $display("FAIL midrun_reset: got %b required 00000",
                     {START, WRITE, rom_we, rsp_valid, cmd_ready});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrun_no_rsp: rsp_valid cycles %0d required 0", bad);
        end

        // Reset landing on the START cycle must clear START without a clock edge.
        core_len = 10;
        send(2'b10, 8'h00, 24'h000000, ok);
        @(negedge clk);
        checks++;
        if (!ok || START !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: ok=%0d start=%b required 1 1", ok, START);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (START !== 1'b0) begin
            errors++;
            $display("FAIL async_start_clear: got %b required 0", START);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        DATA_OUT = 24'h246802;
        send(2'b11, 8'h00, 24'h000000, ok);
        wait_rsp(10, lat);
        checks++;
        if (!ok || lat != 1 || rsp_data !== 24'h246802) begin
            errors++;
            $display("FAIL after_reset_read: ok=%0d latency=%0d data=%h required 1 1 246802",
                     ok, lat, rsp_data);
        end
        ack_rsp();
    endtask

    task automatic test_no_overlap();
        checks++;
        if (overlap !== 1'b0) begin
            errors++;
            $display("FAIL strobe_overlap: got %b required 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_rom_write();
        test_data_write();
        test_read_backpressure();
        test_run();
        test_busy_core();
        test_zero_length();
        test_timeout();
        test_reset_mid_run();
        test_no_overlap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, required to finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
